// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scan-out path.
//   - 640x480@60 horizontal/vertical timing segments (10-bit counts)
//   - FB_WORDS: words per stored bank (320 x 240)
//   - rgb444_t: one RGB444 pixel
//   - swap_state_t: bank-swap request tracker
//   - scan_ctl_t: per-pixel control bits carried alongside the BRAM read
package vga_pkg;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FP      = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BP      = 10'd48;
    localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FP      = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BP      = 10'd33;
    localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int FB_WORDS = 76800;

    typedef logic [11:0] rgb444_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic xhair;
    } scan_ctl_t;

    // Value held in the control delay line while nothing is being displayed.
    localparam scan_ctl_t CTL_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1, xhair: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 raster counters ("counter stage").
// Ports:
//   clk_in          in   vga pixel clock
//   rst_in          in   asynchronous active-low reset
//   hcount_out      out  0..799, current column
//   vcount_out      out  0..524, current line
//   active_out      out  1 inside the 640x480 visible window
//   hsync_out       out  active-low horizontal sync (columns 656..751)
//   vsync_out       out  active-low vertical sync (lines 490..491)
//   frame_start_out out  1 while the counters sit at (0,0), except straight out of reset
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    output logic [9:0] hcount_out,
    output logic [9:0] vcount_out,
    output logic       active_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_start_out
);

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_TOTAL - 10'd1) begin
            hcount_d = '0;
            if (vcount_q == V_TOTAL - 10'd1) begin
                vcount_d = '0;
            end else begin
                vcount_d = vcount_q + 10'd1;
            end
        end
        // Registered from the next count so the pulse lines up with (0,0)
        // yet stays low while reset holds the counters at (0,0).
        frame_start_d = (hcount_d == 10'd0) && (vcount_d == 10'd0);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;
    assign active_out      = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);
    assign hsync_out       = !((hcount_q >= H_VISIBLE + H_FP) && (hcount_q < H_VISIBLE + H_FP + H_SYNC));
    assign vsync_out       = !((vcount_q >= V_VISIBLE + V_FP) && (vcount_q < V_VISIBLE + V_FP + V_SYNC));
    assign frame_start_out = frame_start_q;

endmodule

// File: rtl/framebuffer_scanout.sv
// Read side of the double-buffered framebuffer. Scans the 320x240 bank under
// display at 640x480@60 with 2x2 pixel doubling, optionally overlays a centre
// crosshair, and swaps banks only at the start of vertical blanking.
// Ports:
//   clk_in           in   vga pixel clock
//   rst_in           in   asynchronous active-low reset
//   switch_in        in   one-cycle request to show the other bank
//   crosshair_in     in   level, overlay crosshair when 1
//   rd_addr_out      out  registered BRAM read address
//   rd_data_in       in   BRAM read data (RGB444), RD_LATENCY after rd_addr_out
//   display_bank_out out  bank being scanned
//   swap_done_out    out  one-cycle pulse when a swap takes effect
//   frame_start_out  out  one-cycle pulse at raster (0,0)
//   hsync_out        out  active-low hsync, aligned with rgb_out
//   vsync_out        out  active-low vsync, aligned with rgb_out
//   rgb_out          out  pixel colour, 0 during blanking
//
// Swap request protocol: switch_in is a single-cycle strobe, no ready. A strobe
// is always accepted; strobes arriving while a swap is already pending merge
// into it, so the bank toggles at most once per frame.
module framebuffer_scanout
    import vga_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int ADDR_W     = 18
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              switch_in,
    input  logic              crosshair_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  rgb444_t           rd_data_in,
    output logic              display_bank_out,
    output logic              swap_done_out,
    output logic              frame_start_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output rgb444_t           rgb_out
);

    localparam logic [9:0] XH_H_LO = H_VISIBLE / 10'd2 - 10'd2;
    localparam logic [9:0] XH_H_HI = H_VISIBLE / 10'd2 + 10'd1;
    localparam logic [9:0] XH_V_LO = V_VISIBLE / 10'd2 - 10'd2;
    localparam logic [9:0] XH_V_HI = V_VISIBLE / 10'd2 + 10'd1;

    logic [9:0] hcount, vcount;
    logic       active, hsync, vsync, xhair, swap_point;

    vga_timing u_timing (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hcount_out      (hcount),
        .vcount_out      (vcount),
        .active_out      (active),
        .hsync_out       (hsync),
        .vsync_out       (vsync),
        .frame_start_out (frame_start_out)
    );

    assign swap_point = (hcount == 10'd0) && (vcount == V_VISIBLE);
    assign xhair      = crosshair_in &&
                        (((hcount >= XH_H_LO) && (hcount <= XH_H_HI)) ||
                         ((vcount >= XH_V_LO) && (vcount <= XH_V_HI)));

    // ---------------- bank swap FSM ----------------
    swap_state_t swap_state_q, swap_state_d;
    logic        display_bank_q, display_bank_d;
    logic        swap_done_q, swap_done_d;

    always_comb begin
        swap_state_d   = swap_state_q;
        display_bank_d = display_bank_q;
        swap_done_d    = 1'b0;
        case (swap_state_q)
            IDLE: begin
                // A strobe on the swap point itself is kept for next frame.
                if (switch_in) swap_state_d = PENDING;
            end
            PENDING: begin
                if (swap_point) begin
                    swap_state_d   = IDLE;
                    display_bank_d = !display_bank_q;
                    swap_done_d    = 1'b1;
                end
            end
            default: swap_state_d = IDLE;
        endcase
    end

    // ---------------- address generation ----------------
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] bank_base, hpix;

    // Bank toggles at line 480, so the new base only reaches the address once
    // the next frame becomes active.
    assign bank_base = display_bank_q ? ADDR_W'(FB_WIDTH * FB_HEIGHT) : '0;
    assign hpix      = {{(ADDR_W-9){1'b0}}, hcount[9:1]};

    always_comb begin
        rd_addr_d   = rd_addr_q;
        line_base_d = line_base_q;
        if (active) rd_addr_d = bank_base + line_base_q + hpix;
        if (hcount == H_TOTAL - 10'd1) begin
            if (vcount == V_TOTAL - 10'd1) begin
                line_base_d = '0;
            end else if (vcount[0] && (vcount < V_VISIBLE)) begin
                // Each stored line is shown twice: advance after the odd copy.
                line_base_d = line_base_q + ADDR_W'(FB_WIDTH);
            end
        end
    end

    // ---------------- output pipeline ----------------
    // RD_LATENCY+1 stages match the registered address plus the BRAM latency.
    scan_ctl_t pipe_q [RD_LATENCY+1];
    scan_ctl_t pipe_d [RD_LATENCY+1];
    rgb444_t   rgb_q, rgb_d;
    logic      hsync_q, hsync_d, vsync_q, vsync_d;

    always_comb begin
        pipe_d[0] = {active, hsync, vsync, xhair};
        for (int i = 1; i <= RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
        rgb_d   = pipe_q[RD_LATENCY].active ?
                  (pipe_q[RD_LATENCY].xhair ? 12'hFFF : rd_data_in) : 12'h000;
        hsync_d = pipe_q[RD_LATENCY].hsync;
        vsync_d = pipe_q[RD_LATENCY].vsync;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            swap_state_q   <= IDLE;
            display_bank_q <= 1'b0;
            swap_done_q    <= 1'b0;
            line_base_q    <= '0;
            rd_addr_q      <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) pipe_q[i] <= CTL_IDLE;
            rgb_q          <= '0;
            hsync_q        <= 1'b1;
            vsync_q        <= 1'b1;
        end else begin
            swap_state_q   <= swap_state_d;
            display_bank_q <= display_bank_d;
            swap_done_q    <= swap_done_d;
            line_base_q    <= line_base_d;
            rd_addr_q      <= rd_addr_d;
            for (int i = 0; i <= RD_LATENCY; i++) pipe_q[i] <= pipe_d[i];
            rgb_q          <= rgb_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
        end
    end

    assign rd_addr_out      = rd_addr_q;
    assign display_bank_out = display_bank_q;
    assign swap_done_out    = swap_done_q;
    assign hsync_out        = hsync_q;
    assign vsync_out        = vsync_q;
    assign rgb_out          = rgb_q;

endmodule
